// File: rtl/decode_stage.sv
// ID stage: decode, register file, branch resolve, ID/EX register.
// Ports: IF/ID in, WB write port, redirect to IF, ID/EX out.
// Build option DECODE_RF_BYPASS_EN: same-cycle WB write forwards to reads.
module decode_stage #(
    parameter logic [31:0] SP_INIT    = 32'h0000_0FFC,
    parameter bit          UNDEF_TRAP = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] if_id_instrucao,
    input  logic [31:0] if_id_proximopc,
    input  logic        ex_id_flush,
    input  logic        fw_id_stall,
    input  logic        wb_id_we,
    input  logic [4:0]  wb_id_waddr,
    input  logic [31:0] wb_id_wdata,
    output logic        id_if_selfontepc,
    output logic [1:0]  id_if_seltipopc,
    output logic [31:0] id_if_pcimd2ext,
    output logic [31:0] id_if_rega,
    output logic [31:0] id_if_pcindex,
    output logic [31:0] id_ex_rega,
    output logic [31:0] id_ex_regb,
    output logic [31:0] id_ex_imedext,
    output logic [31:0] id_ex_proximopc,
    output logic [4:0]  id_ex_rs,
    output logic [4:0]  id_ex_rt,
    output logic [4:0]  id_ex_rd,
    output logic [2:0]  id_ex_aluop,
    output logic        id_ex_alusrc,
    output logic        id_ex_memread,
    output logic        id_ex_memwrite,
    output logic        id_ex_regwrite,
    output logic        id_ex_memtoreg
);

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    typedef struct packed {
        logic [31:0] rega;
        logic [31:0] regb;
        logic [31:0] imedext;
        logic [31:0] proximopc;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [2:0]  aluop;
        logic        alusrc;
        logic        memread;
        logic        memwrite;
        logic        regwrite;
        logic        memtoreg;
    } id_ex_t;

    logic [31:0][31:0] rf_q, rf_d;
    id_ex_t            id_ex_q, id_ex_d;

    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] rega_rd;
    logic [31:0] regb_rd;
    logic [31:0] imm_ext;
    id_ex_t      dec;
    logic        sel;
    logic [1:0]  tipo;

    assign op      = if_id_instrucao[31:26];
    assign fn      = if_id_instrucao[5:0];
    assign rs      = if_id_instrucao[25:21];
    assign rt      = if_id_instrucao[20:16];
    assign imm_ext = {{16{if_id_instrucao[15]}}, if_id_instrucao[15:0]};

    // Register file write path; r0 is never written.
    always_comb begin
        rf_d = rf_q;
        if (wb_id_we && (wb_id_waddr != 5'd0)) begin
            rf_d[wb_id_waddr] = wb_id_wdata;
        end
    end

    // Combinational read ports.
    always_comb begin
        rega_rd = rf_q[rs];
        regb_rd = rf_q[rt];
`ifdef DECODE_RF_BYPASS_EN
        if (wb_id_we && (wb_id_waddr == rs)) begin
            rega_rd = wb_id_wdata;
        end
        if (wb_id_we && (wb_id_waddr == rt)) begin
            regb_rd = wb_id_wdata;
        end
`endif
        if (rs == 5'd0) begin
            rega_rd = 32'd0;
        end
        if (rt == 5'd0) begin
            regb_rd = 32'd0;
        end
    end

    // Decoder and branch resolution.
    always_comb begin
        dec           = '0;
        dec.rega      = rega_rd;
        dec.regb      = regb_rd;
        dec.imedext   = imm_ext;
        dec.proximopc = if_id_proximopc;
        dec.rs        = rs;
        dec.rt        = rt;
        dec.rd        = (op == OP_R) ? if_id_instrucao[15:11] : rt;
        sel           = 1'b0;
        tipo          = 2'b00;
        unique case (op)
            OP_R: begin
                unique case (fn)
                    FN_ADD: begin
                        dec.regwrite = 1'b1;
                        dec.aluop    = ALU_ADD;
                    end
                    FN_SUB: begin
                        dec.regwrite = 1'b1;
                        dec.aluop    = ALU_SUB;
                    end
                    FN_AND: begin
                        dec.regwrite = 1'b1;
                        dec.aluop    = ALU_AND;
                    end
                    FN_OR: begin
                        dec.regwrite = 1'b1;
                        dec.aluop    = ALU_OR;
                    end
                    FN_SLT: begin
                        dec.regwrite = 1'b1;
                        dec.aluop    = ALU_SLT;
                    end
                    FN_JR: begin
                        sel  = 1'b1;
                        tipo = 2'b01;
                    end
                    default: ;
                endcase
            end
            OP_ADDI: begin
                dec.regwrite = 1'b1;
                dec.alusrc   = 1'b1;
            end
            OP_LW: begin
                dec.regwrite = 1'b1;
                dec.alusrc   = 1'b1;
                dec.memread  = 1'b1;
                dec.memtoreg = 1'b1;
            end
            OP_SW: begin
                dec.alusrc   = 1'b1;
                dec.memwrite = 1'b1;
            end
            OP_BEQ: begin
                dec.aluop = ALU_SUB;
                sel       = (rega_rd == regb_rd);
            end
            OP_BNE: begin
                dec.aluop = ALU_SUB;
                sel       = (rega_rd != regb_rd);
            end
            OP_J: begin
                sel  = 1'b1;
                tipo = 2'b10;
            end
            // Link value travels as id_ex_proximopc.
            OP_JAL: begin
                sel          = 1'b1;
                tipo         = 2'b10;
                dec.regwrite = 1'b1;
                dec.rd       = 5'd31;
            end
            default: begin
                if (UNDEF_TRAP) begin
                    sel  = 1'b1;
                    tipo = 2'b11;
                end
            end
        endcase
        // Fetch is frozen during a load-use stall.
        if (fw_id_stall) begin
            sel = 1'b0;
        end
        id_ex_d = (ex_id_flush || fw_id_stall) ? '0 : dec;
    end

    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            id_ex_q      <= '0;
            rf_q         <= '0;
            rf_q[29]     <= SP_INIT;
        end else begin
            id_ex_q      <= id_ex_d;
            rf_q         <= rf_d;
        end
    end

    assign id_if_selfontepc = sel;
    assign id_if_seltipopc  = tipo;
    assign id_if_rega       = rega_rd;
    assign id_if_pcimd2ext  = if_id_proximopc + {imm_ext[29:0], 2'b00};
    assign id_if_pcindex    = {if_id_proximopc[31:28],
                               if_id_instrucao[25:0], 2'b00};

    assign id_ex_rega      = id_ex_q.rega;
    assign id_ex_regb      = id_ex_q.regb;
    assign id_ex_imedext   = id_ex_q.imedext;
    assign id_ex_proximopc = id_ex_q.proximopc;
    assign id_ex_rs        = id_ex_q.rs;
    assign id_ex_rt        = id_ex_q.rt;
    assign id_ex_rd        = id_ex_q.rd;
    assign id_ex_aluop     = id_ex_q.aluop;
    assign id_ex_alusrc    = id_ex_q.alusrc;
    assign id_ex_memread   = id_ex_q.memread;
    assign id_ex_memwrite  = id_ex_q.memwrite;
    assign id_ex_regwrite  = id_ex_q.regwrite;
    assign id_ex_memtoreg  = id_ex_q.memtoreg;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: scoreboard of ID/EX words plus direct
// checks of the combinational redirect outputs.
module tb_decode_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] instr, pc;
    logic        flush, stall, we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        sel;
    logic [1:0]  tip;
    logic [31:0] pcimd, if_rega, pcidx;
    logic [31:0] x_rega, x_regb, x_imm, x_pc;
    logic [4:0]  x_rs, x_rt, x_rd;
    logic [2:0]  x_aluop;
    logic        x_alusrc, x_mr, x_mw, x_rw, x_m2r;

    always #5 clock = ~clock;

    decode_stage dut (
        .clock(clock), .reset(reset),
        .if_id_instrucao(instr), .if_id_proximopc(pc),
        .ex_id_flush(flush), .fw_id_stall(stall),
        .wb_id_we(we), .wb_id_waddr(waddr), .wb_id_wdata(wdata),
        .id_if_selfontepc(sel), .id_if_seltipopc(tip),
        .id_if_pcimd2ext(pcimd), .id_if_rega(if_rega),
        .id_if_pcindex(pcidx),
        .id_ex_rega(x_rega), .id_ex_regb(x_regb),
        .id_ex_imedext(x_imm), .id_ex_proximopc(x_pc),
        .id_ex_rs(x_rs), .id_ex_rt(x_rt), .id_ex_rd(x_rd),
        .id_ex_aluop(x_aluop), .id_ex_alusrc(x_alusrc),
        .id_ex_memread(x_mr), .id_ex_memwrite(x_mw),
        .id_ex_regwrite(x_rw), .id_ex_memtoreg(x_m2r)
    );

    // ctl = {aluop, alusrc, memread, memwrite, regwrite, memtoreg}
    localparam logic [7:0] C_NOP  = 8'b000_00000;
    localparam logic [7:0] C_ADD  = 8'b000_00010;
    localparam logic [7:0] C_ADDI = 8'b000_10010;
    localparam logic [7:0] C_LW   = 8'b000_11011;
    localparam logic [7:0] C_BR   = 8'b001_00000;
    localparam logic [7:0] C_JAL  = 8'b000_00010;

`ifdef DECODE_RF_BYPASS_EN
    localparam logic [31:0] R7_SAME = 32'h0000_00AB;
`else
    localparam logic [31:0] R7_SAME = 32'h0000_0022;
`endif

    typedef struct packed {
        logic [31:0] rega;
        logic [31:0] regb;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [7:0]  ctl;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] a, b, i, p,
                                input logic [4:0] s, t, d,
                                input logic [7:0] c);
        exp_t e;
        e.rega = a; e.regb = b; e.imm = i; e.pc = p;
        e.rs = s; e.rt = t; e.rd = d; e.ctl = c;
        return e;
    endfunction

    function automatic logic [31:0] rtype(input logic [4:0] s, t, d,
                                          input logic [5:0] f);
        return {6'd0, s, t, d, 5'd0, f};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] o,
                                          input logic [4:0] s, t,
                                          input logic [15:0] i);
        return {o, s, t, i};
    endfunction

    exp_t zero_e;

    task automatic drive(input logic [31:0] in_i, in_pc,
                         input logic st, fl, w,
                         input logic [4:0] wa, input logic [31:0] wd,
                         input exp_t e);
        @(posedge clock);
        #1;
        instr = in_i; pc = in_pc;
        stall = st; flush = fl;
        we = w; waddr = wa; wdata = wd;
        sb_q.push_back(e);
    endtask

    task automatic wr(input logic [4:0] wa, input logic [31:0] wd);
        drive(32'd0, 32'd0, 1'b0, 1'b0, 1'b1, wa, wd, zero_e);
    endtask

    task automatic retire(input string tag);
        exp_t e;
        @(negedge clock);
        #1;
        check({tag, ".sb"}, sb_q.size(), 1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({tag, ".rega"}, x_rega, e.rega);
            check({tag, ".regb"}, x_regb, e.regb);
            check({tag, ".imm"}, x_imm, e.imm);
            check({tag, ".pc"}, x_pc, e.pc);
            check({tag, ".ctl"},
                  {9'd0, x_rs, x_rt, x_rd, x_aluop, x_alusrc,
                   x_mr, x_mw, x_rw, x_m2r},
                  {9'd0, e.rs, e.rt, e.rd, e.ctl});
        end
    endtask

    task automatic redir(input string tag, input logic s,
                         input logic [1:0] t);
        check({tag, ".sel"}, {31'd0, sel}, {31'd0, s});
        if (s) check({tag, ".tip"}, {30'd0, tip}, {30'd0, t});
    endtask

    initial begin
        zero_e = mk(0, 0, 0, 0, 0, 0, 0, C_NOP);
        reset = 1'b1;
        instr = '0; pc = '0; flush = 0; stall = 0;
        we = 0; waddr = '0; wdata = '0;
        @(posedge clock);
        #1;
        check("rst.rega", x_rega, 0);
        check("rst.pc", x_pc, 0);
        check("rst.ctl", {24'd0, x_rd, x_rw, x_mr, x_alusrc}, 0);
        reset = 1'b0;

        // add r1,r29,r5 reads SP and r5
        drive(rtype(29, 5, 1, 6'h20), 32'h4, 0, 0, 0, 0, 0,
              mk(32'hFFC, 0, 32'h820, 32'h4, 29, 5, 1, C_ADD));
        #1 check("sp.read", if_rega, 32'hFFC);
        retire("add_sp");

        wr(3, 32'h11);
        retire("wr3");
        drive(itype(6'h08, 3, 4, 16'd5), 32'h8, 0, 0, 0, 0, 0,
              mk(32'h11, 0, 5, 32'h8, 3, 4, 4, C_ADDI));
        #1 redir("addi", 0, 0);
        retire("addi");

        wr(1, 32'h55);
        retire("wr1");
        wr(2, 32'h55);
        retire("wr2");
        drive(itype(6'h04, 1, 2, 16'hFFFE), 32'h100, 0, 0, 0, 0, 0,
              mk(32'h55, 32'h55, 32'hFFFF_FFFE, 32'h100, 1, 2, 2, C_BR));
        #1 redir("beq_t", 1, 2'b00);
        check("beq_t.tgt", pcimd, 32'hF8);
        retire("beq_t");

        wr(2, 32'h56);
        retire("wr2b");
        drive(itype(6'h04, 1, 2, 16'hFFFE), 32'h100, 0, 0, 0, 0, 0,
              mk(32'h55, 32'h56, 32'hFFFF_FFFE, 32'h100, 1, 2, 2, C_BR));
        #1 redir("beq_n", 0, 0);
        retire("beq_n");
        drive(itype(6'h05, 1, 2, 16'hFFFE), 32'h100, 0, 0, 0, 0, 0,
              mk(32'h55, 32'h56, 32'hFFFF_FFFE, 32'h100, 1, 2, 2, C_BR));
        #1 redir("bne_t", 1, 2'b00);
        retire("bne_t");
        drive(itype(6'h04, 1, 1, 16'hFFFE), 32'h100, 1, 0, 0, 0, 0,
              zero_e);
        #1 redir("beq_stall", 0, 0);
        retire("beq_stall");

        drive({6'h03, 26'h40}, 32'h200, 0, 0, 0, 0, 0,
              mk(0, 0, 32'h40, 32'h200, 0, 0, 31, C_JAL));
        #1 redir("jal", 1, 2'b10);
        check("jal.idx", pcidx, 32'h100);
        retire("jal");

        drive(rtype(3, 0, 0, 6'h08), 32'h204, 0, 0, 0, 0, 0,
              mk(32'h11, 0, 32'h8, 32'h204, 3, 0, 0, C_NOP));
        #1 redir("jr", 1, 2'b01);
        check("jr.rega", if_rega, 32'h11);
        retire("jr");

        drive(itype(6'h23, 3, 8, 16'd4), 32'h20, 1, 0, 0, 0, 0, zero_e);
        #1 redir("lw_stall", 0, 0);
        retire("lw_stall");
        drive(itype(6'h23, 3, 8, 16'd4), 32'h20, 0, 1, 0, 0, 0, zero_e);
        retire("lw_flush");
        drive(itype(6'h23, 3, 8, 16'd4), 32'h20, 1, 1, 0, 0, 0, zero_e);
        retire("lw_both");
        drive(itype(6'h23, 3, 8, 16'd4), 32'h20, 0, 0, 0, 0, 0,
              mk(32'h11, 0, 4, 32'h20, 3, 8, 8, C_LW));
        retire("lw");

        wr(7, 32'h22);
        retire("wr7");
        drive(rtype(7, 0, 9, 6'h20), 32'h30, 0, 0, 1, 7, 32'hAB,
              mk(R7_SAME, 0, 32'h4820, 32'h30, 7, 0, 9, C_ADD));
        #1 check("byp.read", if_rega, R7_SAME);
        retire("byp");
        drive(rtype(7, 0, 9, 6'h20), 32'h34, 0, 0, 0, 0, 0,
              mk(32'hAB, 0, 32'h4820, 32'h34, 7, 0, 9, C_ADD));
        retire("r7_new");

        drive(32'hFC00_0000, 32'h300, 0, 0, 0, 0, 0,
              mk(0, 0, 0, 32'h300, 0, 0, 0, C_NOP));
        #1 redir("undef", 1, 2'b11);
        retire("undef");

        wr(0, 32'h99);
        retire("wr0");
        drive(rtype(0, 0, 1, 6'h20), 32'h0, 0, 0, 0, 0, 0,
              mk(0, 0, 32'h820, 0, 0, 0, 1, C_ADD));
        #1 check("r0.read", if_rega, 0);
        retire("r0");

        // reset in mid-cycle with a live lw in ID/EX
        drive(itype(6'h23, 3, 8, 16'd4), 32'h20, 0, 0, 0, 0, 0,
              mk(32'h11, 0, 4, 32'h20, 3, 8, 8, C_LW));
        retire("lw2");
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        check("mrst.rega", x_rega, 0);
        check("mrst.ctl", {24'd0, x_rd, x_rw, x_mr, x_alusrc}, 0);
        check("mrst.r3", if_rega, 0);
        instr = rtype(29, 0, 0, 6'h20);
        #1 check("mrst.sp", if_rega, 32'hFFC);
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
